// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory timeout.
// Optional build macro CTRL_BYTE_OPS_EN enables lb/sb decode and the byteOperations lane select.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                memReady,
   output logic                pcWrite,
   output logic                pcWriteCond,
   output logic                branchNe,
   output logic [1:0]          pcSource,
   output logic                iord,
   output logic                memRead,
   output logic                memWrite,
   output logic                irWrite,
   output logic                regWrite,
   output logic                regDst,
   output logic                memToReg,
   output logic                move,
   output logic                ALUsrcA,
   output logic [1:0]          ALUsrcB,
   output logic [ALUOP_W-1:0]  ALUop,
   output logic                byteOperations,
   output logic                illegalOp,
   output logic                memFault
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_ILLEGAL = 3'd0,
      C_RTYPE   = 3'd1,
      C_IMM     = 3'd2,
      C_LOAD    = 3'd3,
      C_STORE   = 3'd4,
      C_MOVE    = 3'd5,
      C_BRANCH  = 3'd6,
      C_JUMP    = 3'd7
   } op_class_t;

   typedef struct packed {
      logic               pc_write;
      logic               pc_write_cond;
      logic               branch_ne;
      logic [1:0]         pc_source;
      logic               iord;
      logic               mem_read;
      logic               mem_write;
      logic               ir_write;
      logic               reg_write;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               move;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic [ALUOP_W-1:0] alu_op;
      logic               byte_ops;
      logic               illegal_op;
      logic               mem_fault;
   } ctl_t;

`ifdef CTRL_BYTE_OPS_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b000110);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_LB    = OPCODE_W'(6'b001001);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b010000);
   localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(6'b010001);
   localparam logic [OPCODE_W-1:0] OP_MOVE  = OPCODE_W'(6'b100000);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b100010);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b111000);

   localparam bit                 TO_EN    = (MEM_TIMEOUT > 0);
   localparam int                 CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   state_t             state_r;
   logic [CNT_W-1:0]   wait_cnt_r;
   op_class_t          op_class_s;
   logic [ALUOP_W-1:0] imm_aluop_s;
   logic               is_byte_s;
   logic               wait_state_s;
   logic               fault_s;
   ctl_t               ctl_s;

   // Opcode classification; byte forms collapse to illegal when the feature is off.
   always_comb begin
      op_class_s  = C_ILLEGAL;
      imm_aluop_s = ALUOP_W'(3'b000);
      is_byte_s   = 1'b0;
      case (opcode)
         OP_RTYPE: op_class_s = C_RTYPE;
         OP_ADDI:  begin op_class_s = C_IMM; imm_aluop_s = ALUOP_W'(3'b000); end
         OP_SUBI:  begin op_class_s = C_IMM; imm_aluop_s = ALUOP_W'(3'b001); end
         OP_ANDI:  begin op_class_s = C_IMM; imm_aluop_s = ALUOP_W'(3'b010); end
         OP_ORI:   begin op_class_s = C_IMM; imm_aluop_s = ALUOP_W'(3'b011); end
         OP_SLTI:  begin op_class_s = C_IMM; imm_aluop_s = ALUOP_W'(3'b100); end
         OP_LW:    op_class_s = C_LOAD;
         OP_LB:    begin op_class_s = BYTE_EN ? C_LOAD : C_ILLEGAL; is_byte_s = BYTE_EN; end
         OP_SW:    op_class_s = C_STORE;
         OP_SB:    begin op_class_s = BYTE_EN ? C_STORE : C_ILLEGAL; is_byte_s = BYTE_EN; end
         OP_MOVE:  op_class_s = C_MOVE;
         OP_BEQ:   op_class_s = C_BRANCH;
         OP_BNE:   op_class_s = C_BRANCH;
         OP_J:     op_class_s = C_JUMP;
         default:  op_class_s = C_ILLEGAL;
      endcase
   end

   // memReady in the timeout cycle wins over the fault.
   assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEM);
   assign fault_s      = TO_EN && wait_state_s && !memReady && (wait_cnt_r == CNT_LAST);

   // State sequencing and the consecutive-wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_FETCH;
         wait_cnt_r <= '0;
      end else begin
         wait_cnt_r <= (TO_EN && wait_state_s && !memReady && !fault_s) ? wait_cnt_r + CNT_ONE : '0;
         case (state_r)
            S_FETCH: begin
               if (!fault_s && memReady) state_r <= S_DECODE;
               else                      state_r <= S_FETCH;
            end
            S_DECODE: begin
               if (op_class_s != C_ILLEGAL) state_r <= S_EXEC;
               else                         state_r <= S_FETCH;
            end
            S_EXEC: begin
               case (op_class_s)
                  C_LOAD, C_STORE:        state_r <= S_MEM;
                  C_RTYPE, C_IMM, C_MOVE: state_r <= S_WB;
                  default:                state_r <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (fault_s)                                               state_r <= S_FETCH;
               else if (memReady && op_class_s == C_LOAD)                  state_r <= S_WB;
               else if (!memReady && (op_class_s == C_LOAD || op_class_s == C_STORE)) state_r <= S_MEM;
               else                                                        state_r <= S_FETCH;
            end
            S_WB:    state_r <= S_FETCH;
            default: state_r <= S_FETCH;
         endcase
      end
   end

   // Moore control decode; FETCH strobes and the MEM write are qualified by this cycle's memReady.
   always_comb begin
      ctl_s = '0;
      case (state_r)
         S_FETCH: begin
            ctl_s.mem_read  = 1'b1;
            ctl_s.alu_src_b = 2'b01;
            ctl_s.ir_write  = memReady;
            ctl_s.pc_write  = memReady;
            ctl_s.mem_fault = fault_s;
         end
         S_DECODE: begin
            ctl_s.alu_src_b  = 2'b11;
            ctl_s.illegal_op = (op_class_s == C_ILLEGAL);
         end
         S_EXEC: begin
            ctl_s.byte_ops = is_byte_s;
            case (op_class_s)
               C_RTYPE: begin
                  ctl_s.alu_src_a = 1'b1;
                  ctl_s.alu_op    = ALUOP_W'(3'b111);
               end
               C_IMM: begin
                  ctl_s.alu_src_b = 2'b10;
                  ctl_s.alu_op    = imm_aluop_s;
               end
               C_LOAD, C_STORE: ctl_s.alu_src_b = 2'b10;
               C_MOVE: begin
                  ctl_s.alu_src_a = 1'b1;
                  ctl_s.alu_src_b = 2'b10;
                  ctl_s.move      = 1'b1;
               end
               C_BRANCH: begin
                  ctl_s.alu_src_a     = 1'b1;
                  ctl_s.alu_op        = ALUOP_W'(3'b001);
                  ctl_s.pc_write_cond = 1'b1;
                  ctl_s.pc_source     = 2'b01;
                  ctl_s.branch_ne     = (opcode == OP_BNE);
               end
               C_JUMP: begin
                  ctl_s.pc_write  = 1'b1;
                  ctl_s.pc_source = 2'b10;
               end
               default: ctl_s.alu_op = ALUOP_W'(3'b000);
            endcase
         end
         S_MEM: begin
            ctl_s.iord      = 1'b1;
            ctl_s.byte_ops  = is_byte_s;
            ctl_s.mem_read  = (op_class_s == C_LOAD);
            ctl_s.mem_write = (op_class_s == C_STORE) && !fault_s;
            ctl_s.mem_fault = fault_s;
         end
         S_WB: begin
            ctl_s.reg_write  = 1'b1;
            ctl_s.byte_ops   = is_byte_s;
            ctl_s.reg_dst    = (op_class_s == C_RTYPE);
            ctl_s.mem_to_reg = (op_class_s == C_LOAD);
            ctl_s.move       = (op_class_s == C_MOVE);
         end
         default: ctl_s = '0;
      endcase
   end

   assign {pcWrite, pcWriteCond, branchNe, pcSource, iord, memRead, memWrite, irWrite,
           regWrite, regDst, memToReg, move, ALUsrcA, ALUsrcB, ALUop, byteOperations,
           illegalOp, memFault} = reset ? '0 : ctl_s;

endmodule
